// File: rtl/nor_sweep_pkg.sv
// Shared function-select constants and FSM state encoding for the NOR equivalence sweeper.
package nor_sweep_pkg;

    localparam logic [1:0] MODE_ANBN = 2'd0;
    localparam logic [1:0] MODE_NAND = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_NOR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nor_func_net.sv
// Bitwise two-input function network built solely from 2-input NOR primitives,
// including the 4:1 function-select mux.
module nor_func_net #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   mode,
    output logic [W-1:0] y
);

    wire       s0_n, s1_n;
    wire [3:0] dec, dec_n;

    nor u_s0_n (s0_n, mode[0], mode[0]);
    nor u_s1_n (s1_n, mode[1], mode[1]);
    nor u_dec0 (dec[0], mode[1], mode[0]);
    nor u_dec1 (dec[1], mode[1], s0_n);
    nor u_dec2 (dec[2], s1_n,    mode[0]);
    nor u_dec3 (dec[3], s1_n,    s0_n);

    for (genvar k = 0; k < 4; k++) begin : g_dec_n
        nor u_inv (dec_n[k], dec[k], dec[k]);
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        wire       na, nb, x1, x2, xnor_ab, and_ab;
        wire [3:0] f, f_n, t;
        wire       o01, o23, o01_n, o23_n, y_n;

        nor u_na   (na, a[i], a[i]);
        nor u_nb   (nb, b[i], b[i]);
        // f[k] is the result for mode k
        nor u_f0   (f[0], a[i], nb);
        nor u_and  (and_ab, na, nb);
        nor u_f1   (f[1], and_ab, and_ab);
        nor u_f3   (f[3], a[i], b[i]);
        nor u_x1   (x1, a[i], f[3]);
        nor u_x2   (x2, b[i], f[3]);
        nor u_xnor (xnor_ab, x1, x2);
        nor u_f2   (f[2], xnor_ab, xnor_ab);

        for (genvar k = 0; k < 4; k++) begin : g_sel
            nor u_fn  (f_n[k], f[k], f[k]);
            nor u_and (t[k], f_n[k], dec_n[k]);
        end

        nor u_o01   (o01, t[0], t[1]);
        nor u_o23   (o23, t[2], t[3]);
        nor u_o01_n (o01_n, o01, o01);
        nor u_o23_n (o23_n, o23, o23);
        nor u_yn    (y_n, o01_n, o23_n);
        nor u_y     (y[i], y_n, y_n);
    end

endmodule

// File: rtl/nor_equiv_sweeper.sv
// Sweeps every minterm of two W-bit operands through a behavioural reference and a
// NOR-only network, counting mismatches and recording the first failing minterm.
module nor_equiv_sweeper
    import nor_sweep_pkg::*;
#(
    parameter  int W    = 2,
    localparam int MT_W = 2 * W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic            inject_en,
    input  logic [MT_W-1:0] inject_mt,
    output logic            busy,
    output logic            done,
    output logic [MT_W-1:0] minterm,
    output logic [W-1:0]    ref_out,
    output logic [W-1:0]    nor_out,
    output logic [MT_W:0]   mismatch_cnt,
    output logic            fail_valid,
    output logic [MT_W-1:0] first_fail
);

    localparam logic [MT_W-1:0] LAST_MT = '1;
    localparam logic [MT_W-1:0] MT_ONE  = {{(MT_W-1){1'b0}}, 1'b1};
    localparam logic [MT_W:0]   CNT_ONE = {{MT_W{1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [1:0]      mode_q;
    logic            inject_en_q;
    logic [MT_W-1:0] inject_mt_q;
    logic [MT_W-1:0] m_q;
    logic            s1_valid;
    logic            start_ok;
    logic [W-1:0]    op_a, op_b;
    logic [W-1:0]    ref_res, net_res, nor_res, fault_mask;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign op_a     = minterm[MT_W-1:W];
    assign op_b     = minterm[W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: defaults come first in every combinational block so no path leaves a value held (no latches).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)             state_nxt = RUN;
            RUN:        if (minterm == LAST_MT) state_nxt = DRAIN;
            DRAIN:                             state_nxt = DONE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ref_res = '0;
        case (mode_q)
            MODE_ANBN: ref_res = ~(op_a | ~op_b);
            MODE_NAND: ref_res = ~(op_a & op_b);
            MODE_XOR:  ref_res = op_a ^ op_b;
            MODE_NOR:  ref_res = ~(op_a | op_b);
            default:   ref_res = '0;
        endcase
    end

    nor_func_net #(.W(W)) u_net (
        .a    (op_a),
        .b    (op_b),
        .mode (mode_q),
        .y    (net_res)
    );

    always_comb begin
        fault_mask    = '0;
        fault_mask[0] = inject_en_q && (minterm == inject_mt_q);
    end
    assign nor_res = net_res ^ fault_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= '0;
            inject_en_q  <= 1'b0;
            inject_mt_q  <= '0;
            minterm      <= '0;
            m_q          <= '0;
            s1_valid     <= 1'b0;
            ref_out      <= '0;
            nor_out      <= '0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
        end else if (start_ok) begin
            mode_q       <= mode;
            inject_en_q  <= inject_en;
            inject_mt_q  <= inject_mt;
            minterm      <= '0;
            s1_valid     <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
        end else begin
            if (state == RUN) begin
                ref_out  <= ref_res;
                nor_out  <= nor_res;
                m_q      <= minterm;
                s1_valid <= 1'b1;
                if (minterm != LAST_MT) minterm <= minterm + MT_ONE;
            end else begin
                s1_valid <= 1'b0;
            end
            // Compare stage trails stage 1 by one cycle, so it also covers DRAIN.
            if (s1_valid && (ref_out != nor_out)) begin
                mismatch_cnt <= mismatch_cnt + CNT_ONE;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    first_fail <= m_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_nor_equiv_sweeper.sv
// Self-checking bench: W=2 and W=3 sweepers driven through directed and random sweeps,
// checked against a truth-table model of the four functions.
module tb_nor_equiv_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start2, start3, inject_en;
    logic [1:0] mode;
    logic [5:0] inj_mt;
    logic       sel3;

    logic       busy2, done2, fv2;
    logic [3:0] m2, ff2;
    logic [1:0] ref2, nor2;
    logic [4:0] cnt2;

    logic       busy3, done3, fv3;
    logic [5:0] m3, ff3;
    logic [2:0] ref3, nor3;
    logic [6:0] cnt3;

    nor_equiv_sweeper #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .inject_en(inject_en),
        .inject_mt(inj_mt[3:0]), .busy(busy2), .done(done2), .minterm(m2),
        .ref_out(ref2), .nor_out(nor2), .mismatch_cnt(cnt2), .fail_valid(fv2),
        .first_fail(ff2)
    );

    nor_equiv_sweeper #(.W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode), .inject_en(inject_en),
        .inject_mt(inj_mt), .busy(busy3), .done(done3), .minterm(m3),
        .ref_out(ref3), .nor_out(nor3), .mismatch_cnt(cnt3), .fail_valid(fv3),
        .first_fail(ff3)
    );

    logic [31:0] o_busy, o_done, o_m, o_ref, o_nor, o_cnt, o_fv, o_ff;
    assign o_busy = sel3 ? 32'(busy3) : 32'(busy2);
    assign o_done = sel3 ? 32'(done3) : 32'(done2);
    assign o_m    = sel3 ? 32'(m3)    : 32'(m2);
    assign o_ref  = sel3 ? 32'(ref3)  : 32'(ref2);
    assign o_nor  = sel3 ? 32'(nor3)  : 32'(nor2);
    assign o_cnt  = sel3 ? 32'(cnt3)  : 32'(cnt2);
    assign o_fv   = sel3 ? 32'(fv3)   : 32'(fv2);
    assign o_ff   = sel3 ? 32'(ff3)   : 32'(ff2);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Per-bit truth table indexed by {a_i, b_i}.
    function automatic logic [3:0] truth_table(input int md);
        case (md)
            0:       return 4'b0010;
            1:       return 4'b0111;
            2:       return 4'b0110;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic int model_ref(input int w, input int md, input int m);
        int a, b, r;
        logic [3:0] tt;
        logic [1:0] idx;
        a  = m >> w;
        b  = m & ((1 << w) - 1);
        r  = 0;
        tt = truth_table(md);
        for (int i = 0; i < w; i++) begin
            idx = {a[i], b[i]};
            if (tt[idx]) r = r | (1 << i);
        end
        return r;
    endfunction

    function automatic int model_nor(input int w, input int md, input bit ie, input int im, input int m);
        return model_ref(w, md, m) ^ ((ie && m == im) ? 1 : 0);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_minterm"}, o_m, 0);
        check({tag, "_ref_out"}, o_ref, 0);
        check({tag, "_nor_out"}, o_nor, 0);
        check({tag, "_mismatch_cnt"}, o_cnt, 0);
        check({tag, "_fail_valid"}, o_fv, 0);
        check({tag, "_first_fail"}, o_ff, 0);
    endtask

    // One full sweep; disturb_at > 0 pulses start and scrambles inputs at that cycle.
    task automatic run_sweep(input int w, input int md, input bit ie, input int im, input int disturb_at);
        int  n, cyc, busy_cycles, exp_cnt, exp_first;
        bit  exp_fv;
        n         = 1 << (2 * w);
        exp_cnt   = 0;
        exp_first = 0;
        exp_fv    = 1'b0;
        for (int m = 0; m < n; m++) begin
            if (model_ref(w, md, m) != model_nor(w, md, ie, im, m)) begin
                if (!exp_fv) exp_first = m;
                exp_fv = 1'b1;
                exp_cnt++;
            end
        end

        sel3      = (w == 3);
        mode      = 2'(md);
        inject_en = ie;
        inj_mt    = 6'(im);
        if (w == 3) start3 = 1'b1;
        else        start2 = 1'b1;
        @(negedge clk);
        mode      = 2'($urandom);
        inject_en = 1'($urandom);
        inj_mt    = 6'($urandom);

        cyc         = 1;
        busy_cycles = 0;
        while (!o_done[0] && cyc < n + 10) begin
            start2 = 1'b0;
            start3 = 1'b0;
            if (o_busy[0]) busy_cycles++;
            if (cyc <= n) check("minterm", o_m, 32'(cyc - 1));
            if (cyc >= 2 && cyc <= n + 1) begin
                check("ref_out", o_ref, 32'(model_ref(w, md, cyc - 2)));
                check("nor_out", o_nor, 32'(model_nor(w, md, ie, im, cyc - 2)));
            end
            if (cyc == disturb_at) begin
                mode = ~mode;
                if (w == 3) start3 = 1'b1;
                else        start2 = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start2 = 1'b0;
        start3 = 1'b0;

        check("done_cycle", 32'(cyc), 32'(n + 2));
        check("busy_cycles", 32'(busy_cycles), 32'(n + 1));
        check("mismatch_cnt", o_cnt, 32'(exp_cnt));
        check("fail_valid", o_fv, 32'(exp_fv));
        check("first_fail", o_ff, 32'(exp_first));
        check("minterm_hold", o_m, 32'(n - 1));
        @(negedge clk);
        check("done_held", o_done, 1);
        check("busy_low", o_busy, 0);
        check("cnt_held", o_cnt, 32'(exp_cnt));
    endtask

    initial begin
        rst       = 1'b1;
        start2    = 1'b0;
        start3    = 1'b0;
        mode      = 2'd0;
        inject_en = 1'b0;
        inj_mt    = 6'd0;
        sel3      = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_w2");
        sel3 = 1'b1;
        #1;
        check_all_zero("rst_w3");
        rst = 1'b0;
        @(negedge clk);

        run_sweep(2, 0, 1'b0, 0, -1);
        run_sweep(2, 0, 1'b1, 5, -1);
        run_sweep(2, 2, 1'b0, 0, -1);
        run_sweep(2, 0, 1'b1, 9, 8);

        // Abort mid-sweep with reset, then confirm a clean restart.
        sel3      = 1'b0;
        mode      = 2'd0;
        inject_en = 1'b1;
        inj_mt    = 6'd3;
        start2    = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", o_busy, 0);
        check("abort_idle_done", o_done, 0);
        run_sweep(2, 0, 1'b1, 3, -1);

        run_sweep(3, 3, 1'b0, 0, -1);
        run_sweep(3, 3, 1'b1, 63, -1);

        for (int k = 0; k < 5; k++)
            run_sweep(2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), -1);
        run_sweep(3, int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 63)), -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nor_equiv_sweeper.md
Name: nor_equiv_sweeper

Overview:
- Sequential, parametrised equivalence checker for two-input bitwise logic functions.
- Enumerates every input combination (minterm) of two W-bit operands.
- Drives a behavioural reference path and a NOR-only gate-network path with each minterm, registers both results, compares them, and reports mismatch count and the first failing minterm.
- Generalises the team's single-bit ~(a|~b) vs. NOR-only lab check to W bits, four selectable functions, fault injection, and a start/busy/done handshake.

Parameters:
- W, 2, operand width in bits. Minterm space is 2^(2W). Legal range 1..8.
- MT_W, 2*W, derived minterm width. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when in IDLE or DONE
- mode  in  2  function select, latched on start: 0 = ~(a|~b), 1 = ~(a&b), 2 = a^b, 3 = ~(a|b)
- inject_en  in  1  enables a fault on the NOR path; latched on start
- inject_mt  in  MT_W  minterm at which the fault is injected; latched on start
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; held until the next accepted start or rst
- minterm  out  MT_W  minterm currently applied
- ref_out  out  W  registered reference result
- nor_out  out  W  registered NOR-path result
- mismatch_cnt  out  MT_W+1  number of mismatching minterms in the current sweep
- fail_valid  out  1  set on the first mismatch of the sweep
- first_fail  out  MT_W  minterm of the first mismatch; valid only when fail_valid = 1

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0, including the minterm counter and all latched controls.
- Operand mapping: a = m[MT_W-1:W], b = m[W-1:0].
- Reference path: behavioural expression selected by mode_q.
- NOR path: built only from 2-input nor primitives.
  - When inject_en_q=1 and m == inject_mt_q, bit 0 of the NOR result is inverted.
- FSM states and transitions:
  - IDLE: start → RUN. On entry to RUN: latch mode, inject_en and inject_mt; clear counter, mismatch_cnt, fail_valid and first_fail.
  - RUN: each cycle, apply counter m to both paths. Register ref_out, nor_out and m_q (stage 1). Increment the counter. When m == 2^MT_W-1, do not wrap; go to DRAIN.
  - Compare stage: runs in every cycle after stage 1 holds valid data (RUN from the 2nd cycle, and DRAIN).
    - If ref_out != nor_out: mismatch_cnt += 1.
    - If this is the first mismatch of the sweep: fail_valid ← 1 and first_fail ← m_q.
  - DRAIN: one cycle for the final compare, then → DONE.
  - DONE: done=1 and results are held. start → RUN with a fresh sweep.
- start while busy is ignored. Latched mode and inject values are unaffected by input changes during a sweep.
- Latency: done rises 2^MT_W + 2 cycles after the start edge (18 cycles for W=2).
- Width rule: mismatch_cnt is MT_W+1 bits so that 2^MT_W mismatches fit without overflow.
- rst asserted mid-sweep aborts immediately to IDLE with all outputs 0. No partial results are retained.
- minterm output reflects the counter value; it holds 2^MT_W-1 in DRAIN and DONE.

Decomposition:
- Shared package nor_sweep_pkg:
  - mode constants MODE_ANBN=0, MODE_NAND=1, MODE_XOR=2, MODE_NOR=3
  - state enum IDLE/RUN/DRAIN/DONE
- One sub-module, nor_func_net (parameter W):
  - Combinational, bitwise, NOR-primitive-only implementation of the four modes plus an output mux.
  - The mux is also NOR-built.
  - The sweeper instantiates it once. The reference path stays inline.

Test Plan:
- W=2, mode=0, inject_en=0, pulse start → busy for 17 cycles, done at cycle 18, mismatch_cnt=0, fail_valid=0.
- W=2, mode=0, inject_en=1, inject_mt=5 → mismatch_cnt=1, fail_valid=1, first_fail=5.
- W=2, mode=2, observe minterm 6 (a=01, b=10) → ref_out=nor_out=11 one cycle after minterm=6. Also mode=0 at minterm 6 → 10.
- Start pulse during RUN (cycle 8) → ignored; done still at cycle 18, counts unchanged. Change mode mid-sweep → no effect.
- rst pulse at cycle 10 of a sweep with inject at minterm 3 → all outputs 0 and state IDLE. A new start yields a full 18-cycle sweep with mismatch_cnt=1.
- W=3, mode=3, no inject → 64 minterms, done at cycle 66, mismatch_cnt=0. Then restart from DONE with inject_mt=63 → mismatch_cnt=1, first_fail=63.
